// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register-file operand buses, the
// multiply/divide unit and the HI/LO register.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic               hilo_en;
  logic               dz;
  logic [2*WIDTH-1:0] result;

  // Requester side: issues operations, observes status and result.
  modport master (
    output start, op, a, b,
    input  busy, done, hilo_en, dz, result
  );

  // Unit side: consumes operations, produces status and result.
  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_en, dz, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit feeding the HI/LO register pair.
// One bit per clock: shift-add multiply, restoring divide, both on operand
// magnitudes, followed by a single sign-fixup cycle.
// op: 00 MUL, 01 MULU, 10 DIV, 11 DIVU (op[1] = divide, op[0] = unsigned).
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          clr,
  mul_div_unit_if.slave bus
);
  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic               sa_q;
  logic               sb_q;
  logic               bz_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [W2-1:0]      acc_q;      // product accumulator, or {remainder, quotient}
  logic [W2-1:0]      mcand_q;    // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   mplier_q;   // multiplier (shifted right) or divisor (held)
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [W2-1:0]      result_q;

  logic               sa_d;
  logic               sb_d;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic [W2-1:0]      mul_acc_d;
  logic               div_ge_d;
  logic [WIDTH-1:0]   div_diff_d;
  logic [W2-1:0]      div_acc_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_d;
  logic [W2-1:0]      fix_result_d;

  // Operand signs and magnitudes as seen at the accepting edge.
  always_comb begin
    sa_d = ~bus.op[0] & bus.a[WIDTH-1];
    sb_d = ~bus.op[0] & bus.b[WIDTH-1];
    if (sa_d) begin
      a_mag_d = (~bus.a) + WIDTH'(1);
    end else begin
      a_mag_d = bus.a;
    end
    if (sb_d) begin
      b_mag_d = (~bus.b) + WIDTH'(1);
    end else begin
      b_mag_d = bus.b;
    end
  end

  // One iteration of shift-add multiply and of restoring divide.
  always_comb begin
    if (mplier_q[0]) begin
      mul_acc_d = acc_q + mcand_q;
    end else begin
      mul_acc_d = acc_q;
    end
    // Shifted partial remainder is acc_q[W2-1:WIDTH-1] (WIDTH+1 bits wide).
    div_ge_d   = (acc_q[W2-1:WIDTH-1] >= {1'b0, mplier_q});
    div_diff_d = acc_q[W2-2:WIDTH-1] - mplier_q;
    if (div_ge_d) begin
      div_acc_d = {div_diff_d, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_d = {acc_q[W2-2:0], 1'b0};
    end
  end

  // Sign correction and divide-by-zero override applied in the FIX cycle.
  always_comb begin
    quo_d = acc_q[WIDTH-1:0];
    rem_d = acc_q[W2-1:WIDTH];
    fix_result_d = acc_q;
    if (!op_q[1]) begin
      if (!op_q[0] && (sa_q ^ sb_q)) begin
        fix_result_d = (~acc_q) + W2'(1);
      end else begin
        fix_result_d = acc_q;
      end
    end else if (bz_q) begin
      fix_result_d = {a_raw_q, {WIDTH{1'b1}}};
    end else begin
      if (!op_q[0] && (sa_q ^ sb_q)) begin
        quo_d = (~acc_q[WIDTH-1:0]) + WIDTH'(1);
      end else begin
        quo_d = acc_q[WIDTH-1:0];
      end
      if (!op_q[0] && sa_q) begin
        rem_d = (~acc_q[W2-1:WIDTH]) + WIDTH'(1);
      end else begin
        rem_d = acc_q[W2-1:WIDTH];
      end
      fix_result_d = {rem_d, quo_d};
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      a_raw_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q     <= bus.op;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= (bus.b == '0);
            a_raw_q  <= bus.a;
            mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
            mplier_q <= b_mag_d;
            if (bus.op[1]) begin
              acc_q <= {{WIDTH{1'b0}}, a_mag_d};
            end else begin
              acc_q <= '0;
            end
            result_q <= '0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (op_q[1]) begin
            acc_q    <= div_acc_d;
            mplier_q <= mplier_q;
          end else begin
            acc_q    <= mul_acc_d;
            mplier_q <= mplier_q >> 1;
          end
          mcand_q <= mcand_q << 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_FIX: begin
          result_q <= fix_result_d;
          dz_q     <= op_q[1] & bz_q;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hilo_en = done_q;
  assign bus.dz      = dz_q;
  assign bus.result  = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the stimulus process pushes expected
// {result, dz, done cycle} entries computed by a plain-arithmetic model; a
// monitor pops and compares on every done pulse.
module tb_mul_div_unit;
  localparam int WIDTH = 32;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  logic clk;
  logic clr;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: {dz, {HI, LO}} from ordinary integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = ua * ub; return {1'b0, p}; end
      2'b10: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        q = ua / ub;
        r = ua % ub;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Wait for an idle slot, issue one operation, and queue its expectation.
  task automatic issue(input string name, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    logic [64:0] m;
    int         n;
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout: actual=busy required=idle", name);
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
    m     = ref_model(op, a, b);
    e.res = m[63:0];
    e.dz  = m[64];
    e.cyc = cyc + WIDTH + 1;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1 || bus.hilo_en === 1'b1) begin
      check("hilo_en_eq_done", {63'h0, bus.hilo_en}, {63'h0, bus.done});
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual=done result=%h required=no_done", bus.result);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_result"}, bus.result, e.res);
        check({e.name, "_dz"}, {63'h0, bus.dz}, {63'h0, e.dz});
        check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    clr       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("reset_busy",   {63'h0, bus.busy},    64'h0);
    check("reset_done",   {63'h0, bus.done},    64'h0);
    check("reset_hilo",   {63'h0, bus.hilo_en}, 64'h0);
    check("reset_dz",     {63'h0, bus.dz},      64'h0);
    check("reset_result", bus.result,           64'h0);

    // MUL 7 * -3 with busy profile: high in cycles 1..34, low in cycle 35.
    issue("mul_7_m3", 2'b00, 32'd7, 32'hFFFFFFFD);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      check($sformatf("busy_cycle_%0d", k), {63'h0, bus.busy}, (k <= 34) ? 64'h1 : 64'h0);
    end

    issue("mulu_max",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue("div_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2);
    issue("divu_100_7",    2'b11, 32'd100, 32'd7);
    issue("divu_by_zero",  2'b11, 32'd100, 32'd0);
    issue("div_overflow",  2'b10, 32'h80000000, 32'hFFFFFFFF);
    issue("div_neg_by_zero", 2'b10, 32'hFFFFFF00, 32'd0);

    // Start pulse in cycle 5 of a MUL must be ignored; the next start is
    // issued in the first idle cycle after DONE (back-to-back).
    issue("mul_ignore", 2'b00, 32'd12345, 32'hFFFF0001);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h12345678;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    issue("mulu_b2b", 2'b01, 32'h0000FFFF, 32'h00010001);

    // clr in cycle 10 of a DIV aborts it with no done pulse.
    issue("div_aborted", 2'b10, 32'hFFFFF000, 32'd3);
    void'(sb_q.pop_back());
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_busy",   {63'h0, bus.busy}, 64'h0);
    check("clr_result", bus.result,        64'h0);
    check("clr_dz",     {63'h0, bus.dz},   64'h0);
    repeat (40) @(negedge clk);
    issue("mulu_3_5", 2'b01, 32'd3, 32'd5);

    // Randomised operations, with zero divisors and small values mixed in.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'h0;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 200)) - 32'd100;
      if ($urandom_range(0, 3) == 0 && rb != 32'h0) rb = 32'($urandom_range(1, 20));
      issue($sformatf("rand_%0d_op%0d", i, rop), rop, ra, rb);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
